// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Polyphonic voice scheduler. Takes complete MIDI messages and
//                assigns Note On to a voice (retrigger, else lowest free, else
//                steal oldest). Releases voices on Note Off, Note On with
//                velocity 0 and All Notes Off (CC123). Drives per-voice
//                gate/note/velocity/trigger.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_msg_valid,
    output logic                    o_msg_ready,
    input  logic [1:0]              i_msg_len,
    input  logic [7:0]              i_msg0,
    input  logic [7:0]              i_msg1,
    input  logic [7:0]              i_msg2,
    output logic [NUM_VOICES-1:0]   o_gate,
    output logic [7*NUM_VOICES-1:0] o_note,
    output logic [7*NUM_VOICES-1:0] o_vel,
    output logic [NUM_VOICES-1:0]   o_trig
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_decode = 2'd1;
    localparam logic [1:0] c_st_scan   = 2'd2;
    localparam logic [1:0] c_st_apply  = 2'd3;

    localparam logic [1:0] c_cls_drop = 2'd0;
    localparam logic [1:0] c_cls_on   = 2'd1;
    localparam logic [1:0] c_cls_off  = 2'd2;
    localparam logic [1:0] c_cls_all  = 2'd3;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] c_age_max  = '1;

    logic [1:0]            r_state;
    logic [1:0]            r_len;
    logic [3:0]            r_status;
    logic [7:0]            r_msg1;
    logic [7:0]            r_msg2;

    logic [IDX_W-1:0]      r_idx;
    logic                  r_match_vld;
    logic [IDX_W-1:0]      r_match_idx;
    logic                  r_free_vld;
    logic [IDX_W-1:0]      r_free_idx;
    logic                  r_old_vld;
    logic [IDX_W-1:0]      r_old_idx;
    logic [AGE_W-1:0]      r_old_age;

    logic [NUM_VOICES-1:0] r_gate;
    logic [6:0]            r_note [NUM_VOICES];
    logic [6:0]            r_vel  [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_trig;

    logic [1:0]            w_cls;
    logic [IDX_W-1:0]      w_target;
    logic                  w_scan_gate;
    logic [6:0]            w_scan_note;
    logic [AGE_W-1:0]      w_scan_age;

    assign o_msg_ready = (r_state == c_st_idle);
    assign o_gate      = r_gate;
    assign o_trig      = r_trig;

    assign w_scan_gate = r_gate[r_idx];
    assign w_scan_note = r_note[r_idx];
    assign w_scan_age  = r_age[r_idx];

    // Retrigger beats free voice, free voice beats stealing the oldest.
    assign w_target = r_match_vld ? r_match_idx :
                      r_free_vld  ? r_free_idx  : r_old_idx;

    // Classify the held message; velocity-0 Note On counts as Note Off.
    always_comb begin
        w_cls = c_cls_drop;
        if (r_status == 4'h9 && r_len == 2'd3 && r_msg2 != 8'd0)
            w_cls = c_cls_on;
        else if ((r_status == 4'h8 && r_len == 2'd3) || (r_status == 4'h9 && r_msg2 == 8'd0))
            w_cls = c_cls_off;
        else if (r_status == 4'hB && r_len == 2'd3 && r_msg1 == 8'd123)
            w_cls = c_cls_all;
    end

    // Control FSM and message capture on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= c_st_idle;
            r_len    <= '0;
            r_status <= '0;
            r_msg1   <= '0;
            r_msg2   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_msg_valid) begin
                        r_len    <= i_msg_len;
                        r_status <= i_msg0[7:4];
                        r_msg1   <= i_msg1;
                        r_msg2   <= i_msg2;
                        r_state  <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    case (w_cls)
                        c_cls_drop: r_state <= c_st_idle;
                        c_cls_all:  r_state <= c_st_apply;
                        default:    r_state <= c_st_scan;
                    endcase
                end
                c_st_scan: begin
                    if (r_idx == c_last_idx)
                        r_state <= c_st_apply;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Walk the voices one per cycle, recording match / first free / oldest.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == c_st_decode) begin
            r_idx       <= '0;
            r_match_vld <= 1'b0;
            r_match_idx <= '0;
            r_free_vld  <= 1'b0;
            r_free_idx  <= '0;
            r_old_vld   <= 1'b0;
            r_old_idx   <= '0;
            r_old_age   <= '0;
        end else if (r_state == c_st_scan) begin
            r_idx <= r_idx + IDX_W'(1);
            if (w_scan_gate && w_scan_note == r_msg1[6:0] && !r_match_vld) begin
                r_match_vld <= 1'b1;
                r_match_idx <= r_idx;
            end
            if (!w_scan_gate && !r_free_vld) begin
                r_free_vld <= 1'b1;
                r_free_idx <= r_idx;
            end
            // Strict '>' keeps the lowest index on equal ages.
            if (w_scan_gate && (!r_old_vld || w_scan_age > r_old_age)) begin
                r_old_vld <= 1'b1;
                r_old_idx <= r_idx;
                r_old_age <= w_scan_age;
            end
        end
    end

    // Voice state update in APPLY; trigger is a single-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gate <= '0;
            r_trig <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= '0;
                r_vel[v]  <= '0;
                r_age[v]  <= '0;
            end
        end else begin
            r_trig <= '0;
            if (r_state == c_st_apply) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    case (w_cls)
                        c_cls_on: begin
                            if (IDX_W'(v) == w_target) begin
                                r_gate[v] <= 1'b1;
                                r_note[v] <= r_msg1[6:0];
                                r_vel[v]  <= r_msg2[6:0];
                                r_age[v]  <= '0;
                                r_trig[v] <= 1'b1;
                            end else if (r_gate[v] && r_age[v] != c_age_max) begin
                                r_age[v] <= r_age[v] + AGE_W'(1);
                            end
                        end
                        c_cls_off: begin
                            // Free voices keep age 0 so they never look old.
                            if (r_gate[v] && r_note[v] == r_msg1[6:0]) begin
                                r_gate[v] <= 1'b0;
                                r_age[v]  <= '0;
                            end
                        end
                        c_cls_all: begin
                            r_gate[v] <= 1'b0;
                            r_age[v]  <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    generate
        for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_pack
            assign o_note[7*gv +: 7] = r_note[gv];
            assign o_vel[7*gv +: 7]  = r_vel[gv];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Self-checking bench for voice_allocator. A behavioural
//                allocator model produces the expected voice state and
//                latency for every message; results are queued on accept
//                and compared when the allocator becomes ready again.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid;
    logic            rdy;
    logic [1:0]      len;
    logic [7:0]      m0, m1, m2;
    logic [NV-1:0]   gate;
    logic [7*NV-1:0] note, vel;
    logic [NV-1:0]   trig;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_msg_valid(valid),
        .o_msg_ready(rdy),
        .i_msg_len  (len),
        .i_msg0     (m0),
        .i_msg1     (m1),
        .i_msg2     (m2),
        .o_gate     (gate),
        .o_note     (note),
        .o_vel      (vel),
        .o_trig     (trig)
    );

    typedef struct {
        logic [NV-1:0]   gate;
        logic [7*NV-1:0] note;
        logic [7*NV-1:0] vel;
        logic [NV-1:0]   trig;
        int              lat;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference voice state
    logic       mg[NV];
    logic [6:0] mn[NV];
    logic [6:0] mv[NV];
    int         ma[NV];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mg[v] = 1'b0; mn[v] = '0; mv[v] = '0; ma[v] = 0;
        end
    endtask

    function automatic exp_t model_step(input logic [1:0] l, input logic [7:0] b0, b1, b2);
        exp_t e;
        int   tgt;
        int   cls;
        logic [NV-1:0] t;
        t   = '0;
        cls = 0;
        if (b0[7:4] == 4'h9 && l == 2'd3 && b2 != 8'd0) cls = 1;
        else if ((b0[7:4] == 4'h8 && l == 2'd3) || (b0[7:4] == 4'h9 && b2 == 8'd0)) cls = 2;
        else if (b0[7:4] == 4'hB && l == 2'd3 && b1 == 8'd123) cls = 3;
        if (cls == 1) begin
            tgt = -1;
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && mg[v] && mn[v] == b1[6:0]) tgt = v;
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && !mg[v]) tgt = v;
            if (tgt < 0) begin
                tgt = 0;
                for (int v = 1; v < NV; v++)
                    if (ma[v] > ma[tgt]) tgt = v;
            end
            for (int v = 0; v < NV; v++) begin
                if (v == tgt) begin
                    mg[v] = 1'b1; mn[v] = b1[6:0]; mv[v] = b2[6:0]; ma[v] = 0; t[v] = 1'b1;
                end else if (mg[v] && ma[v] < (2**AW - 1)) begin
                    ma[v]++;
                end
            end
        end else if (cls == 2) begin
            for (int v = 0; v < NV; v++)
                if (mg[v] && mn[v] == b1[6:0]) begin mg[v] = 1'b0; ma[v] = 0; end
        end else if (cls == 3) begin
            for (int v = 0; v < NV; v++) begin mg[v] = 1'b0; ma[v] = 0; end
        end
        for (int v = 0; v < NV; v++) begin
            e.gate[v]       = mg[v];
            e.note[7*v +: 7] = mn[v];
            e.vel[7*v +: 7]  = mv[v];
        end
        e.trig = t;
        e.lat  = (cls == 0) ? 1 : (cls == 3) ? 2 : NV + 2;
        return e;
    endfunction

    // Called at a negedge. hold=1 keeps valid high for back-to-back traffic.
    task automatic drive(input logic [1:0] l, input logic [7:0] b0, b1, b2, input bit hold);
        int            j;
        exp_t          e;
        logic [NV-1:0] tacc;
        j = 0;
        while (!rdy && j < 50) begin @(negedge clk); j++; end
        valid = 1'b1; len = l; m0 = b0; m1 = b1; m2 = b2;
        @(posedge clk);
        sbq.push_back(model_step(l, b0, b1, b2));
        @(negedge clk);
        if (!hold) begin
            valid = 1'b0;
            len = 2'($urandom); m0 = 8'($urandom); m1 = 8'($urandom); m2 = 8'($urandom);
        end
        j = 0;
        tacc = '0;
        while (!rdy && j < 100) begin
            tacc |= trig;
            @(negedge clk);
            j++;
        end
        e = sbq.pop_front();
        check("latency", 64'(j), 64'(e.lat));
        check("trig_busy", 64'(tacc), 64'(0));
        check("gate", 64'(gate), 64'(e.gate));
        check("note", 64'(note), 64'(e.note));
        check("vel", 64'(vel), 64'(e.vel));
        check("trig", 64'(trig), 64'(e.trig));
        if (!hold) begin
            @(negedge clk);
            check("trig_clear", 64'(trig), 64'(0));
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; len = '0; m0 = '0; m1 = '0; m2 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 64'(rdy), 64'(1));
        check("rst_gate", 64'(gate), 64'(0));
        check("rst_note", 64'(note), 64'(0));
        check("rst_vel", 64'(vel), 64'(0));
        check("rst_trig", 64'(trig), 64'(0));

        // First note lands on voice 0
        drive(2'd3, 8'h90, 8'h3C, 8'h64, 0);
        check("t1_gate", 64'(gate), 64'h1);
        check("t1_note0", 64'(note[6:0]), 64'h3C);
        check("t1_vel0", 64'(vel[6:0]), 64'h64);
        // Fill remaining voices, then steal the oldest (voice 0)
        drive(2'd3, 8'h91, 8'h40, 8'h10, 0);
        drive(2'd3, 8'h92, 8'h43, 8'h20, 0);
        drive(2'd3, 8'h93, 8'h47, 8'h30, 0);
        drive(2'd3, 8'h90, 8'h48, 8'h7F, 0);
        check("t2_gate", 64'(gate), 64'hF);
        check("t2_note0", 64'(note[6:0]), 64'h48);
        // All notes off, then a dropped two-byte message
        drive(2'd3, 8'hB0, 8'h7B, 8'h00, 0);
        check("t5_gate", 64'(gate), 64'h0);
        drive(2'd2, 8'hC0, 8'h05, 8'h00, 0);
        // Note Off frees voice 0, next note reuses it
        drive(2'd3, 8'h90, 8'h3C, 8'h40, 0);
        drive(2'd3, 8'h90, 8'h40, 8'h40, 0);
        drive(2'd3, 8'h80, 8'h3C, 8'h00, 0);
        check("t3_gate", 64'(gate), 64'h2);
        drive(2'd3, 8'h90, 8'h45, 8'h40, 0);
        check("t3_note0", 64'(note[6:0]), 64'h45);
        drive(2'd3, 8'hB5, 8'h7B, 8'h00, 0);
        // Velocity-0 release, then retrigger of the same note
        drive(2'd3, 8'h90, 8'h3C, 8'h40, 0);
        drive(2'd3, 8'h90, 8'h3C, 8'h00, 0);
        check("t4_gate_off", 64'(gate), 64'h0);
        drive(2'd3, 8'h90, 8'h3C, 8'h40, 0);
        drive(2'd3, 8'h90, 8'h3C, 8'h50, 0);
        check("t4_gate_retrig", 64'(gate), 64'h1);
        // Randomised traffic: small note set, stray high bits, saturating ages
        for (int i = 0; i < 60; i++) begin
            int        k;
            logic [7:0] nb;
            k  = $urandom_range(0, 9);
            nb = {1'($urandom), 7'(8'h3C + $urandom_range(0, 5))};
            if (k < 6)       drive(2'd3, 8'h90, nb, 8'($urandom_range(1, 255)), 0);
            else if (k < 8)  drive(2'd3, 8'h80, nb, 8'($urandom), 0);
            else if (k == 8) drive(2'd3, 8'h90, nb, 8'h00, 0);
            else             drive(2'd3, 8'hB0, (i % 3 == 0) ? 8'h7B : 8'h07, 8'h00, 0);
        end
        // Back-to-back with valid held high
        drive(2'd3, 8'hB0, 8'h7B, 8'h00, 1);
        drive(2'd3, 8'h90, 8'h50, 8'h11, 1);
        drive(2'd3, 8'h90, 8'h51, 8'h22, 1);
        drive(2'd2, 8'hD0, 8'h01, 8'h00, 1);
        drive(2'd3, 8'h80, 8'h50, 8'h00, 0);
        // Reset during SCAN discards the message
        valid = 1'b1; len = 2'd3; m0 = 8'h90; m1 = 8'h60; m2 = 8'h33;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid_rst_ready", 64'(rdy), 64'(1));
        check("mid_rst_gate", 64'(gate), 64'(0));
        check("mid_rst_note", 64'(note), 64'(0));
        check("mid_rst_vel", 64'(vel), 64'(0));
        check("mid_rst_trig", 64'(trig), 64'(0));
        drive(2'd3, 8'h90, 8'h61, 8'h44, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
